// File: rtl/proc_io_bridge.sv
// I/O bridge between the float processor core and integer ports: per-channel input FIFOs,
// int<->float conversion and strobed output registers. Define IOB_STATUS_EN for sticky error flags.
`timescale 1ns/1ps
module proc_io_bridge #(
  parameter int NBMANT = 19,
  parameter int NBEXPO = 8,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int FDEPTH = 8,
  localparam int FW  = NBMANT + NBEXPO + 1,
  localparam int AIW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN*NBMANT-1:0] ext_in,
  input  logic [NUIOIN-1:0]        ext_in_vld,
  output logic [NUIOIN-1:0]        ext_in_rdy,
  output logic [NUIOOU*NBMANT-1:0] ext_out,
  output logic [NUIOOU-1:0]        ext_out_vld,
  input  logic                     proc_req_in,
  input  logic [AIW-1:0]           addr_in,
  output logic [FW-1:0]            in_float,
  output logic                     stall,
  input  logic                     proc_out_en,
  input  logic [AOW-1:0]           addr_out,
  input  logic [FW-1:0]            out_float,
  input  logic                     clr_status,
  output logic [NUIOIN-1:0]        err_empty,
  output logic                     err_addr
);
  localparam int PW   = $clog2(FDEPTH);
  localparam int CW   = PW + 1;
  localparam int BIAS = (1 << (NBEXPO - 1)) - 1;
  localparam logic [NBMANT:0] POS_LIM = (NBMANT+1)'((1 << (NBMANT - 1)) - 1);
  localparam logic [NBMANT:0] NEG_LIM = (NBMANT+1)'(1 << (NBMANT - 1));

  // Normalised sign-magnitude float with hidden bit; exact since |v| <= 2^(NBMANT-1).
  function automatic logic [FW-1:0] int2float(input logic [NBMANT-1:0] v);
    logic [NBMANT-1:0] mag;
    logic [NBMANT-1:0] frac;
    int pos;
    mag = v[NBMANT-1] ? (~v + 1'b1) : v;
    pos = 0;
    for (int b = 0; b < NBMANT; b++) if (mag[b]) pos = b;
    frac = mag << (NBMANT - pos);
    if (mag == '0) return '0;
    return {v[NBMANT-1], NBEXPO'(BIAS + pos), frac};
  endfunction

  // Truncates toward zero and saturates to the signed NBMANT-bit range.
  function automatic logic [NBMANT-1:0] float2int(input logic [FW-1:0] f);
    logic              sgn;
    logic [NBEXPO-1:0] e;
    logic [NBMANT:0]   full;
    logic [NBMANT:0]   mag;
    logic              sat;
    int                u;
    sgn  = f[FW-1];
    e    = f[FW-2 -: NBEXPO];
    full = {1'b1, f[NBMANT-1:0]};
    u    = int'(e) - BIAS;
    sat  = (u >= NBMANT);
    if (u < 0 || sat) mag = '0;
    else              mag = full >> (NBMANT - u);
    if (!sgn) return (sat || mag > POS_LIM) ? POS_LIM[NBMANT-1:0] : mag[NBMANT-1:0];
    return (sat || mag > NEG_LIM) ? NEG_LIM[NBMANT-1:0] : NBMANT'(~mag + 1'b1);
  endfunction

  logic [NBMANT-1:0] mem_q    [NUIOIN][FDEPTH];
  logic [PW-1:0]     rd_ptr_q [NUIOIN];
  logic [PW-1:0]     rd_ptr_d [NUIOIN];
  logic [PW-1:0]     wr_ptr_q [NUIOIN];
  logic [PW-1:0]     wr_ptr_d [NUIOIN];
  logic [CW-1:0]     cnt_q    [NUIOIN];
  logic [CW-1:0]     cnt_d    [NUIOIN];
  logic [NUIOIN-1:0] push, pop, empty;
  logic [NBMANT-1:0] head;
  logic              sel_empty, rd_ok;

  // Handshake: a sample transfers on a clock edge where ext_in_vld[i] && ext_in_rdy[i];
  // ready depends only on occupancy, so a same-cycle pop never re-opens a full FIFO.
  always_comb begin
    rd_ok     = 32'(addr_in) < NUIOIN;
    head      = '0;
    sel_empty = 1'b1;
    for (int i = 0; i < NUIOIN; i++) begin
      empty[i]      = (cnt_q[i] == '0);
      ext_in_rdy[i] = cnt_q[i] < CW'(FDEPTH);
      push[i]       = ext_in_vld[i] && ext_in_rdy[i];
      pop[i]        = proc_req_in && (addr_in == AIW'(i)) && !empty[i];
      wr_ptr_d[i]   = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i]   = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]      = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (addr_in == AIW'(i)) begin
        head      = mem_q[i][rd_ptr_q[i]];
        sel_empty = empty[i];
      end
    end
    stall    = proc_req_in && rd_ok && sel_empty;
    in_float = (rd_ok && !sel_empty) ? int2float(head) : '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUIOIN; i++) begin
      if (rst) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end else begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUIOIN; i++)
      if (!rst && push[i]) mem_q[i][wr_ptr_q[i]] <= ext_in[i*NBMANT +: NBMANT];
  end

  logic [NUIOOU-1:0][NBMANT-1:0] ext_out_q, ext_out_d;
  logic [NUIOOU-1:0]             ext_out_vld_q, ext_out_vld_d;
  logic [NBMANT-1:0]             wr_val;

  always_comb begin
    wr_val        = float2int(out_float);
    ext_out_d     = ext_out_q;
    ext_out_vld_d = '0;
    for (int j = 0; j < NUIOOU; j++) begin
      if (proc_out_en && addr_out == AOW'(j)) begin
        ext_out_d[j]     = wr_val;
        ext_out_vld_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_out_q     <= '0;
      ext_out_vld_q <= '0;
    end else begin
      ext_out_q     <= ext_out_d;
      ext_out_vld_q <= ext_out_vld_d;
    end
  end

  assign ext_out     = ext_out_q;
  assign ext_out_vld = ext_out_vld_q;

`ifdef IOB_STATUS_EN
  logic [NUIOIN-1:0] err_empty_q, err_empty_d;
  logic              err_addr_q, err_addr_d;

  // Set events are OR-ed in after the clear so a coincident set wins.
  always_comb begin
    err_empty_d = (clr_status ? '0 : err_empty_q) | (empty & {NUIOIN{proc_req_in}} &
                  (NUIOIN'(1) << addr_in));
    err_addr_d  = (clr_status ? 1'b0 : err_addr_q) | (proc_req_in && !rd_ok) |
                  (proc_out_en && !(32'(addr_out) < NUIOOU));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_empty_q <= '0;
      err_addr_q  <= 1'b0;
    end else begin
      err_empty_q <= err_empty_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_empty = err_empty_q;
  assign err_addr  = err_addr_q;
`else
  logic unused_clr;
  assign unused_clr = clr_status;
  assign err_empty  = '0;
  assign err_addr   = 1'b0;
`endif
endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed bench for proc_io_bridge: conversion tables, FIFO fill/drain, stall, writes, status, reset.
`timescale 1ns/1ps
module tb_proc_io_bridge;
  localparam int NBMANT = 19;
  localparam int NBEXPO = 8;
  localparam int NUIOIN = 3;
  localparam int NUIOOU = 4;
  localparam int FDEPTH = 8;
  localparam int FW     = NBMANT + NBEXPO + 1;
  localparam int AIW    = 2;
  localparam int AOW    = 2;
`ifdef IOB_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUIOIN*NBMANT-1:0] ext_in;
  logic [NUIOIN-1:0]        ext_in_vld, ext_in_rdy;
  logic [NUIOOU*NBMANT-1:0] ext_out;
  logic [NUIOOU-1:0]        ext_out_vld;
  logic                     proc_req_in, stall, proc_out_en, clr_status, err_addr;
  logic [AIW-1:0]           addr_in;
  logic [AOW-1:0]           addr_out;
  logic [FW-1:0]            in_float, out_float;
  logic [NUIOIN-1:0]        err_empty;

  always #5 clk = ~clk;

  proc_io_bridge #(.NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU),
                   .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .ext_in(ext_in), .ext_in_vld(ext_in_vld), .ext_in_rdy(ext_in_rdy),
    .ext_out(ext_out), .ext_out_vld(ext_out_vld), .proc_req_in(proc_req_in),
    .addr_in(addr_in), .in_float(in_float), .stall(stall), .proc_out_en(proc_out_en),
    .addr_out(addr_out), .out_float(out_float), .clr_status(clr_status),
    .err_empty(err_empty), .err_addr(err_addr)
  );

  typedef struct { int ch; logic [NBMANT-1:0] smp; logic [FW-1:0] flt; } rd_vec_t;
  typedef struct { int ch; logic [FW-1:0] flt; logic [NBMANT-1:0] val; } wr_vec_t;

  rd_vec_t           rd_tab [7];
  wr_vec_t           wr_tab [10];
  logic [FW-1:0]     flt_of [10];
  logic [FW-1:0]     exp_q  [$];
  logic [NBMANT-1:0] shadow [NUIOOU];
  logic [FW-1:0]     e_flt;
  int                n_chk = 0;
  int                n_fail = 0;

  function automatic logic [FW-1:0] mkf(input logic s, input logic [7:0] e, input logic [18:0] m);
    return {s, e, m};
  endfunction

  function automatic logic [NUIOOU*NBMANT-1:0] pack_out();
    logic [NUIOOU*NBMANT-1:0] r;
    for (int j = 0; j < NUIOOU; j++) r[j*NBMANT +: NBMANT] = shadow[j];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [NBMANT-1:0] v);
    ext_in[ch*NBMANT +: NBMANT] = v;
    ext_in_vld[ch] = 1'b1;
    next();
    ext_in_vld[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ext_in = '0; ext_in_vld = '0; proc_req_in = 1'b0; addr_in = '0;
    proc_out_en = 1'b0; addr_out = '0; out_float = '0; clr_status = 1'b0;

    rd_tab[0] = '{2, 19'd5,      mkf(1'b0, 8'd129, 19'h20000)};
    rd_tab[1] = '{0, 19'h7FFFF,  mkf(1'b1, 8'd127, 19'h00000)};
    rd_tab[2] = '{1, 19'h40000,  mkf(1'b1, 8'd145, 19'h00000)};
    rd_tab[3] = '{2, 19'h3FFFF,  mkf(1'b0, 8'd144, 19'h7FFFC)};
    rd_tab[4] = '{1, 19'd100,    mkf(1'b0, 8'd133, 19'h48000)};
    rd_tab[5] = '{0, 19'd1,      mkf(1'b0, 8'd127, 19'h00000)};
    rd_tab[6] = '{2, 19'd0,      mkf(1'b0, 8'd0,   19'h00000)};

    wr_tab[0] = '{3, mkf(1'b1, 8'd133, 19'h48000), 19'h7FF9C};
    wr_tab[1] = '{3, mkf(1'b0, 8'd156, 19'h6E6B2), 19'h3FFFF};
    wr_tab[2] = '{0, mkf(1'b1, 8'd156, 19'h6E6B2), 19'h40000};
    wr_tab[3] = '{1, mkf(1'b0, 8'd145, 19'h00000), 19'h3FFFF};
    wr_tab[4] = '{2, mkf(1'b1, 8'd145, 19'h00000), 19'h40000};
    wr_tab[5] = '{0, mkf(1'b0, 8'd128, 19'h60000), 19'd3};
    wr_tab[6] = '{1, mkf(1'b1, 8'd128, 19'h60000), 19'h7FFFD};
    wr_tab[7] = '{2, mkf(1'b0, 8'd126, 19'h7FFFF), 19'd0};
    wr_tab[8] = '{3, mkf(1'b0, 8'd0,   19'h00000), 19'd0};
    wr_tab[9] = '{1, mkf(1'b0, 8'd144, 19'h7FFFC), 19'h3FFFF};

    flt_of[0] = '0;
    flt_of[1] = mkf(1'b0, 8'd127, 19'h00000);
    flt_of[2] = mkf(1'b0, 8'd128, 19'h00000);
    flt_of[3] = mkf(1'b0, 8'd128, 19'h40000);
    flt_of[4] = mkf(1'b0, 8'd129, 19'h00000);
    flt_of[5] = mkf(1'b0, 8'd129, 19'h20000);
    flt_of[6] = mkf(1'b0, 8'd129, 19'h40000);
    flt_of[7] = mkf(1'b0, 8'd129, 19'h60000);
    flt_of[8] = mkf(1'b0, 8'd130, 19'h00000);
    flt_of[9] = mkf(1'b0, 8'd130, 19'h10000);
    for (int j = 0; j < NUIOOU; j++) shadow[j] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_rdy",       128'(ext_in_rdy),  128'(3'b111));
    check("reset_ext_out",   128'(ext_out),     128'(0));
    check("reset_out_vld",   128'(ext_out_vld), 128'(0));
    check("reset_in_float",  128'(in_float),    128'(0));
    check("reset_stall",     128'(stall),       128'(0));
    check("reset_err_empty", 128'(err_empty),   128'(0));
    check("reset_err_addr",  128'(err_addr),    128'(0));
    next();

    // Push one sample, read it the next cycle, confirm the channel drained.
    for (int k = 0; k < 7; k++) begin
      push(rd_tab[k].ch, rd_tab[k].smp);
      proc_req_in = 1'b1;
      addr_in = AIW'(rd_tab[k].ch);
      @(negedge clk);
      check($sformatf("rd%0d_float", k), 128'(in_float), 128'(rd_tab[k].flt));
      check($sformatf("rd%0d_stall", k), 128'(stall), 128'(0));
      next();
      proc_req_in = 1'b0;
      @(negedge clk);
      check($sformatf("rd%0d_drained", k), 128'(in_float), 128'(0));
      next();
    end

    // Held request on an empty channel, then a push under the request.
    addr_in = 2'd1;
    proc_req_in = 1'b1;
    @(negedge clk);
    check("empty_stall",      128'(stall),    128'(1));
    check("empty_in_float",   128'(in_float), 128'(0));
    next();
    ext_in[1*NBMANT +: NBMANT] = 19'h7FFFD;
    ext_in_vld[1] = 1'b1;
    @(negedge clk);
    check("push_cycle_stall", 128'(stall),    128'(1));
    next();
    ext_in_vld[1] = 1'b0;
    @(negedge clk);
    check("held_req_stall",   128'(stall),    128'(0));
    check("held_req_float",   128'(in_float), 128'(mkf(1'b1, 8'd128, 19'h40000)));
    next();
    proc_req_in = 1'b0;
    @(negedge clk);
    check("held_req_popped",  128'(in_float), 128'(0));
    check("err_empty_set",    128'(err_empty), STAT ? 128'(3'b010) : 128'(0));
    clr_status = 1'b1;
    next();
    clr_status = 1'b0;
    @(negedge clk);
    check("err_empty_clr",    128'(err_empty), 128'(0));
    next();

    // Fill channel 0, exercise full behaviour, then drain in order.
    addr_in = 2'd0;
    for (int v = 0; v < 8; v++) begin
      ext_in[0 +: NBMANT] = NBMANT'(v);
      ext_in_vld[0] = 1'b1;
      @(negedge clk);
      check($sformatf("fill%0d_rdy", v), 128'(ext_in_rdy[0]), 128'(1));
      exp_q.push_back(flt_of[v]);
      next();
    end
    ext_in[0 +: NBMANT] = 19'd99;
    proc_req_in = 1'b1;
    @(negedge clk);
    check("full_rdy",  128'(ext_in_rdy[0]), 128'(0));
    check("full_head", 128'(in_float), 128'(exp_q[0]));
    next();
    e_flt = exp_q.pop_front();
    ext_in[0 +: NBMANT] = 19'd8;
    @(negedge clk);
    check("pushpop_rdy",  128'(ext_in_rdy[0]), 128'(1));
    check("pushpop_head", 128'(in_float), 128'(exp_q[0]));
    e_flt = exp_q.pop_front();
    exp_q.push_back(flt_of[8]);
    next();
    ext_in[0 +: NBMANT] = 19'd9;
    proc_req_in = 1'b0;
    @(negedge clk);
    check("refill_rdy", 128'(ext_in_rdy[0]), 128'(1));
    exp_q.push_back(flt_of[9]);
    next();
    ext_in_vld[0] = 1'b0;
    @(negedge clk);
    check("refull_rdy", 128'(ext_in_rdy[0]), 128'(0));
    next();
    proc_req_in = 1'b1;
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      e_flt = exp_q.pop_front();
      check($sformatf("drain%0d_float", d), 128'(in_float), 128'(e_flt));
      check($sformatf("drain%0d_stall", d), 128'(stall), 128'(0));
      next();
    end
    proc_req_in = 1'b0;
    @(negedge clk);
    check("drained_float", 128'(in_float), 128'(0));
    check("drained_rdy",   128'(ext_in_rdy[0]), 128'(1));
    next();

    // Output writes from the table, one at a time.
    for (int k = 0; k < 10; k++) begin
      addr_out = AOW'(wr_tab[k].ch);
      out_float = wr_tab[k].flt;
      proc_out_en = 1'b1;
      next();
      proc_out_en = 1'b0;
      shadow[wr_tab[k].ch] = wr_tab[k].val;
      @(negedge clk);
      check($sformatf("wr%0d_ext_out", k), 128'(ext_out), 128'(pack_out()));
      check($sformatf("wr%0d_vld", k), 128'(ext_out_vld), 128'(4'b0001 << wr_tab[k].ch));
      next();
    end
    @(negedge clk);
    check("wr_idle_vld", 128'(ext_out_vld), 128'(0));
    next();

    // Back-to-back writes give one strobe per cycle.
    addr_out = 2'd0;
    out_float = flt_of[5];
    proc_out_en = 1'b1;
    next();
    addr_out = 2'd1;
    out_float = mkf(1'b1, 8'd127, 19'h00000);
    shadow[0] = 19'd5;
    @(negedge clk);
    check("b2b_vld0", 128'(ext_out_vld), 128'(4'b0001));
    check("b2b_out0", 128'(ext_out), 128'(pack_out()));
    next();
    proc_out_en = 1'b0;
    shadow[1] = 19'h7FFFF;
    @(negedge clk);
    check("b2b_vld1", 128'(ext_out_vld), 128'(4'b0010));
    check("b2b_out1", 128'(ext_out), 128'(pack_out()));
    next();

    // Out-of-range read: no pop, no stall, sticky address error.
    push(0, 19'd7);
    addr_in = 2'd3;
    proc_req_in = 1'b1;
    @(negedge clk);
    check("badrd_float", 128'(in_float), 128'(0));
    check("badrd_stall", 128'(stall), 128'(0));
    next();
    proc_req_in = 1'b0;
    addr_in = 2'd0;
    @(negedge clk);
    check("badrd_no_pop",   128'(in_float), 128'(flt_of[7]));
    check("badrd_err_addr", 128'(err_addr), 128'(STAT));
    check("badrd_err_empty", 128'(err_empty), 128'(0));
    clr_status = 1'b1;
    proc_req_in = 1'b1;
    addr_in = 2'd3;
    next();
    clr_status = 1'b0;
    proc_req_in = 1'b0;
    addr_in = 2'd0;
    @(negedge clk);
    check("set_beats_clr", 128'(err_addr), 128'(STAT));
    clr_status = 1'b1;
    next();
    clr_status = 1'b0;
    @(negedge clk);
    check("err_addr_clr", 128'(err_addr), 128'(0));
    next();

    // Reset with samples buffered, a coincident push and a coincident write.
    push(0, 19'd1);
    push(0, 19'd2);
    push(0, 19'd3);
    proc_req_in = 1'b1;
    addr_in = 2'd3;
    next();
    proc_req_in = 1'b0;
    addr_in = 2'd0;
    rst = 1'b1;
    ext_in[2*NBMANT +: NBMANT] = 19'd42;
    ext_in_vld[2] = 1'b1;
    addr_out = 2'd2;
    out_float = flt_of[9];
    proc_out_en = 1'b1;
    next();
    rst = 1'b0;
    ext_in_vld[2] = 1'b0;
    proc_out_en = 1'b0;
    @(negedge clk);
    check("rst2_rdy",       128'(ext_in_rdy),  128'(3'b111));
    check("rst2_in_float",  128'(in_float),    128'(0));
    check("rst2_ext_out",   128'(ext_out),     128'(0));
    check("rst2_out_vld",   128'(ext_out_vld), 128'(0));
    check("rst2_err_empty", 128'(err_empty),   128'(0));
    check("rst2_err_addr",  128'(err_addr),    128'(0));
    next();
    addr_in = 2'd2;
    proc_req_in = 1'b1;
    @(negedge clk);
    check("rst2_push_dropped", 128'(stall), 128'(1));
    next();
    proc_req_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
